// File: rtl/pc_sched_if.sv
// Scheduler-side bundle between next-PC logic, the OS control path and the program counter.
interface pc_sched_if #(
  parameter int ADDR_W   = 32,
  parameter int NUM_PROC = 4,
  parameter int PID_W    = 2,
  parameter int CNT_W    = 32
);
  logic [ADDR_W-1:0]   pc_next;
  logic                stall;
  logic                step;
  logic                dispatch;
  logic [PID_W-1:0]    dispatch_pid;
  logic                end_process;
  logic                set_quantum;
  logic [CNT_W-1:0]    quantum_in;

  logic [ADDR_W-1:0]   pc_out;
  logic                user_mode;
  logic [PID_W-1:0]    cur_pid;
  logic                preempt;
  logic [NUM_PROC-1:0] done_mask;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    output pc_next, stall, step, dispatch, dispatch_pid, end_process, set_quantum, quantum_in,
    input  pc_out, user_mode, cur_pid, preempt, done_mask, instr_count
  );

  modport slave (
    input  pc_next, stall, step, dispatch, dispatch_pid, end_process, set_quantum, quantum_in,
    output pc_out, user_mode, cur_pid, preempt, done_mask, instr_count
  );
endinterface

// File: rtl/pc_sched.sv
// Program counter with a preemptive round-trip scheduler: OS dispatches a user process,
// which runs for a quantum (or until it ends) and is then returned to the OS.
module pc_sched #(
  parameter int                ADDR_W       = 32,
  parameter int                NUM_PROC     = 4,
  parameter int                PID_W        = 2,
  parameter int                CNT_W        = 32,
  parameter int                BASE_QUANTUM = 82,
  parameter logic [ADDR_W-1:0] OS_ENTRY     = '0,
  parameter logic [ADDR_W-1:0] PROC_STRIDE  = 'h100
) (
  input logic       CLK,
  input logic       reset,
  pc_sched_if.slave bus
);

  typedef enum logic {OS, USER} state_t;

  state_t              state, stateNext;
  logic [ADDR_W-1:0]   pcOut, pcOutNext;
  logic [ADDR_W-1:0]   osRet, osRetNext;
  logic [PID_W-1:0]    curPid, curPidNext;
  logic                preempt, preemptNext;
  logic [NUM_PROC-1:0] doneMask, doneMaskNext;
  logic [CNT_W-1:0]    instrCount, instrCountNext;
  logic [CNT_W-1:0]    quantumReg;
  logic [CNT_W:0]      limit;

  logic [ADDR_W-1:0]   pcTable [NUM_PROC];
  logic                tblWe;
  logic [PID_W-1:0]    tblIdx;
  logic [ADDR_W-1:0]   tblData;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] startPc(input logic [PID_W-1:0] pid);
    logic [ADDR_W-1:0] slot;
    slot = ADDR_W'(pid) + ADDR_W'(1);
    return slot * PROC_STRIDE;
  endfunction

  // One extra bit so a huge extension can never wrap below the base quantum.
  assign limit = (CNT_W+1)'(BASE_QUANTUM) + {1'b0, quantumReg};

  always_comb begin
    stateNext      = state;
    pcOutNext      = pcOut;
    osRetNext      = osRet;
    curPidNext     = curPid;
    preemptNext    = 1'b0;
    doneMaskNext   = doneMask;
    instrCountNext = instrCount;
    tblWe          = 1'b0;
    tblIdx         = curPid;
    tblData        = bus.pc_next;

    case (state)
      OS: begin
        if (bus.dispatch) begin
          osRetNext                      = bus.pc_next;
          pcOutNext                      = pcTable[bus.dispatch_pid];
          curPidNext                     = bus.dispatch_pid;
          doneMaskNext[bus.dispatch_pid] = 1'b0;
          instrCountNext                 = '0;
          stateNext                      = USER;
        end else begin
          pcOutNext = bus.pc_next;
        end
      end
      USER: begin
        // Stall freezes the process; end/expiry wait for the first unstalled cycle.
        if (bus.stall) begin
          if (bus.step) begin
            pcOutNext      = bus.pc_next;
            instrCountNext = satInc(instrCount);
          end
        end else if (bus.end_process) begin
          doneMaskNext[curPid] = 1'b1;
          tblWe                = 1'b1;
          tblData              = startPc(curPid);
          pcOutNext            = osRet;
          instrCountNext       = '0;
          preemptNext          = 1'b1;
          stateNext            = OS;
        end else if ({1'b0, instrCount} >= limit) begin
          tblWe          = 1'b1;
          pcOutNext      = osRet;
          instrCountNext = '0;
          preemptNext    = 1'b1;
          stateNext      = OS;
        end else begin
          pcOutNext      = bus.pc_next;
          instrCountNext = satInc(instrCount);
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state      <= OS;
      pcOut      <= OS_ENTRY;
      osRet      <= OS_ENTRY;
      curPid     <= '0;
      preempt    <= 1'b0;
      doneMask   <= '0;
      instrCount <= '0;
      quantumReg <= '0;
    end else begin
      state      <= stateNext;
      pcOut      <= pcOutNext;
      osRet      <= osRetNext;
      curPid     <= curPidNext;
      preempt    <= preemptNext;
      doneMask   <= doneMaskNext;
      instrCount <= instrCountNext;
      if (bus.set_quantum) quantumReg <= bus.quantum_in;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PROC; i++) pcTable[i] <= startPc(PID_W'(i));
    end else if (tblWe) begin
      pcTable[tblIdx] <= tblData;
    end
  end

  assign bus.pc_out      = pcOut;
  assign bus.user_mode   = (state == USER);
  assign bus.cur_pid     = curPid;
  assign bus.preempt     = preempt;
  assign bus.done_mask   = doneMask;
  assign bus.instr_count = instrCount;

endmodule

// File: tb/tb_pc_sched.sv
// Randomized and directed bench for pc_sched against a process-level scheduler model.
module tb_pc_sched;
  localparam int          ADDR_W   = 32;
  localparam int          NUM_PROC = 4;
  localparam int          PID_W    = 2;
  localparam int          CNT_W    = 32;
  localparam int          BASE_Q   = 4;
  localparam logic [31:0] STRIDE   = 32'h100;
  localparam longint      CNT_MAX  = 64'hFFFF_FFFF;

  logic CLK;
  logic reset;
  int   nCompared = 0;
  int   nMismatch = 0;

  pc_sched_if #(.ADDR_W(ADDR_W), .NUM_PROC(NUM_PROC), .PID_W(PID_W), .CNT_W(CNT_W)) bus ();

  pc_sched #(
    .ADDR_W(ADDR_W), .NUM_PROC(NUM_PROC), .PID_W(PID_W), .CNT_W(CNT_W),
    .BASE_QUANTUM(BASE_Q), .OS_ENTRY(32'h0), .PROC_STRIDE(STRIDE)
  ) dut (
    .CLK(CLK),
    .reset(reset),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: what the scheduler should look like after each clock.
  bit          mUser;
  int          mPid;
  logic [31:0] mPc, mOsRet;
  logic [31:0] mTbl [NUM_PROC];
  longint      mCnt, mQ;
  bit   [3:0]  mDone;
  bit          mPre;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    longint lim, qNext;
    if (!reset) begin
      mPc = 0; mOsRet = 0; mUser = 0; mPid = 0; mPre = 0; mDone = 0; mCnt = 0; mQ = 0;
      for (int i = 0; i < NUM_PROC; i++) mTbl[i] = (i + 1) * STRIDE;
    end else begin
      qNext = bus.set_quantum ? longint'(bus.quantum_in) : mQ;
      lim   = BASE_Q + mQ;
      mPre  = 0;
      if (!mUser) begin
        if (bus.dispatch) begin
          mOsRet = bus.pc_next;
          mPid   = int'(bus.dispatch_pid);
          mPc    = mTbl[mPid];
          mDone[mPid] = 0;
          mCnt   = 0;
          mUser  = 1;
        end else mPc = bus.pc_next;
      end else if (bus.stall) begin
        if (bus.step) begin
          mPc  = bus.pc_next;
          mCnt = (mCnt == CNT_MAX) ? mCnt : mCnt + 1;
        end
      end else if (bus.end_process || mCnt >= lim) begin
        if (bus.end_process) begin
          mDone[mPid] = 1;
          mTbl[mPid]  = (mPid + 1) * STRIDE;
        end else mTbl[mPid] = bus.pc_next;
        mPc = mOsRet; mCnt = 0; mPre = 1; mUser = 0;
      end else begin
        mPc  = bus.pc_next;
        mCnt = (mCnt == CNT_MAX) ? mCnt : mCnt + 1;
      end
      mQ = qNext;
    end
  endtask

  task automatic cyc();
    modelStep();
    @(posedge CLK);
    #1;
    chk("pc_out", bus.pc_out, mPc);
    chk("user_mode", bus.user_mode, mUser);
    chk("cur_pid", bus.cur_pid, mPid);
    chk("preempt", bus.preempt, mPre);
    chk("done_mask", bus.done_mask, mDone);
    chk("instr_count", bus.instr_count, mCnt);
  endtask

  task automatic idle();
    reset            = 1'b1;
    bus.pc_next      = mPc + 32'd4;
    bus.stall        = 1'b0;
    bus.step         = 1'b0;
    bus.dispatch     = 1'b0;
    bus.dispatch_pid = '0;
    bus.end_process  = 1'b0;
    bus.set_quantum  = 1'b0;
    bus.quantum_in   = '0;
  endtask

  task automatic dispatchPid(input logic [31:0] ret, input int pid);
    idle();
    bus.pc_next      = ret;
    bus.dispatch     = 1'b1;
    bus.dispatch_pid = PID_W'(pid);
    cyc();
  endtask

  task automatic loadQuantum(input logic [31:0] q);
    idle();
    bus.set_quantum = 1'b1;
    bus.quantum_in  = q;
    cyc();
  endtask

  initial begin
    int n, pre;
    mPc = 0;
    idle();
    reset = 1'b0;
    cyc(); cyc();
    chk("rst_pc", bus.pc_out, 32'h0);
    chk("rst_user", bus.user_mode, 1'b0);

    // Dispatch, a full quantum, preemption and resume
    dispatchPid(32'h40, 1);
    chk("t2_pc", bus.pc_out, 32'h200);
    chk("t2_user", bus.user_mode, 1'b1);
    chk("t2_pid", bus.cur_pid, 2'd1);
    for (int k = 0; k < 4; k++) begin
      idle(); cyc();
      chk("t3_seq", bus.pc_out, 32'h204 + 32'(4 * k));
    end
    idle(); cyc();
    chk("t3_preempt", bus.preempt, 1'b1);
    chk("t3_osret", bus.pc_out, 32'h40);
    idle(); cyc();
    chk("t3_pulse", bus.preempt, 1'b0);
    dispatchPid(32'h80, 1);
    chk("t3_resume", bus.pc_out, 32'h214);

    // Reset in the middle of a user process
    idle(); cyc();
    idle(); reset = 1'b0; cyc();
    chk("t1_pc", bus.pc_out, 32'h0);
    chk("t1_user", bus.user_mode, 1'b0);
    chk("t1_done", bus.done_mask, 4'b0);
    chk("t1_cnt", bus.instr_count, 32'h0);
    chk("t1_pre", bus.preempt, 1'b0);

    // Extended quantum and a huge extension that must not wrap
    loadQuantum(32'd3);
    dispatchPid(32'h44, 3);
    n = 0;
    while (n < 40) begin
      idle(); cyc();
      if (bus.preempt) break;
      n++;
    end
    chk("t4_advances", n, 7);
    loadQuantum(32'hFFFF_FFFF);
    dispatchPid(32'h48, 0);
    pre = 0;
    repeat (30) begin
      idle(); cyc();
      if (bus.preempt) pre++;
    end
    chk("t4_nowrap", pre, 0);
    chk("t4_cnt", bus.instr_count, 32'd30);
    idle(); bus.end_process = 1'b1; cyc();
    chk("t4_end_pre", bus.preempt, 1'b1);
    chk("t4_done0", bus.done_mask[0], 1'b1);

    // Stepping under stall past the limit, preempt on release
    loadQuantum(32'd0);
    dispatchPid(32'h500, 1);
    repeat (4) begin idle(); cyc(); end
    idle(); bus.stall = 1'b1; bus.step = 1'b1; cyc();
    idle(); bus.stall = 1'b1; bus.end_process = 1'b1; cyc();
    idle(); bus.stall = 1'b1; bus.step = 1'b1; cyc();
    chk("t5_cnt", bus.instr_count, 32'd6);
    chk("t5_nopre", bus.preempt, 1'b0);
    chk("t5_user", bus.user_mode, 1'b1);
    idle(); cyc();
    chk("t5_pre", bus.preempt, 1'b1);
    chk("t5_pc", bus.pc_out, 32'h500);

    // End of process coinciding with expiry
    idle(); reset = 1'b0; cyc();
    dispatchPid(32'h600, 2);
    repeat (4) begin idle(); cyc(); end
    idle(); bus.end_process = 1'b1; cyc();
    chk("t6_done", bus.done_mask, 4'b0100);
    chk("t6_pc", bus.pc_out, 32'h600);
    chk("t6_pre", bus.preempt, 1'b1);
    idle(); cyc();
    dispatchPid(32'h700, 2);
    chk("t6_restart", bus.pc_out, 32'h300);
    chk("t6_clear", bus.done_mask, 4'b0000);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      reset            = ($urandom_range(0, 199) != 0);
      bus.pc_next      = $urandom;
      bus.stall        = mUser && ($urandom_range(0, 3) == 0);
      bus.step         = 1'($urandom_range(0, 1));
      bus.end_process  = ($urandom_range(0, 15) == 0);
      bus.dispatch     = mUser ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
      bus.dispatch_pid = PID_W'($urandom_range(0, NUM_PROC - 1));
      bus.set_quantum  = ($urandom_range(0, 31) == 0);
      bus.quantum_in   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 9));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
